rbchunk: RTL and testbench

//  Parametrised successor to the single-byte rabin hash tap.

---
 rtl/rbchunk.sv | 180 ++++++++++++++++++
 tb/tb_rbchunk.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rbchunk.sv
// Content-defined chunker: rolling gear hash over a src byte stream, one
// two-word record per chunk to dst. Optional RBCHUNK_FORCED_FLAG_EN marks forced cuts in word1[63].
module rbchunk #(
  parameter int unsigned SRC_W     = 64,
  parameter int unsigned MASK_BITS = 13,
  parameter logic [63:0] MAGIC     = 64'h78,
  parameter int unsigned MIN_CHUNK = 2048,
  parameter int unsigned MAX_CHUNK = 65536,
  parameter logic [63:0] GEAR_SEED = 64'h9E3779B97F4A7C15,
  parameter int unsigned DC_BIT    = 8,
  localparam int unsigned BYTES    = SRC_W / 8,
  localparam int unsigned IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             m_enable,
  input  logic [23:0]      dc,
  input  logic [SRC_W-1:0] m_src,
  input  logic             m_src_last,
  input  logic [IDX_W-1:0] m_src_nbytes,
  input  logic             m_src_empty,
  output logic             m_src_getn,
  output logic [63:0]      m_dst,
  output logic             m_dst_putn,
  output logic             m_dst_last,
  input  logic             m_dst_full,
  output logic             m_endn
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_POP   = 3'd2;
  localparam logic [2:0] S_EMIT0 = 3'd3;
  localparam logic [2:0] S_EMIT1 = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;

  localparam logic [63:0] MASK = (MASK_BITS == 0)  ? 64'h0 :
                                 (MASK_BITS >= 64) ? '1 :
                                 ((64'h1 << MASK_BITS) - 64'h1);

  logic [2:0]       r_state, w_state;
  logic [63:0]      r_hash, w_hash;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [31:0]      r_len, w_len;
  logic [30:0]      r_offset, w_offset;
  logic [63:0]      r_cap_hash, w_cap_hash;
  logic             r_final, w_final_nxt;
  logic             r_pending_pop, w_pending_pop;
  logic             w_forced_nxt;

  logic [7:0]  w_byte;
  logic [63:0] w_h_next;
  logic [31:0] w_len_next;
  logic        w_natural, w_forced, w_word_end, w_final, w_cut;
  logic        w_flag;
  logic [63:0] w_dst;
  logic        w_emit;
  logic        w_unused;

  assign w_unused = ^dc;

  // Byte replicated across the 64-bit gear lane, truncated/zero-filled for narrow words.
  function automatic logic [63:0] rep_byte(input logic [7:0] b);
    logic [63:0] r;
    r = 64'h0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < BYTES) r[8*i +: 8] = b;
    end
    return r;
  endfunction

  assign w_byte     = m_src[{r_idx, 3'b000} +: 8];
  assign w_h_next   = (r_hash << 1) + (rep_byte(w_byte) ^ GEAR_SEED);
  assign w_len_next = r_len + 32'd1;
  assign w_natural  = (w_len_next >= 32'(MIN_CHUNK)) && ((w_h_next & MASK) == (MAGIC & MASK));
  assign w_forced   = (w_len_next == 32'(MAX_CHUNK));
  assign w_word_end = (r_idx == IDX_W'(BYTES - 1)) ||
                      (m_src_last && (m_src_nbytes != '0) && (r_idx == (m_src_nbytes - IDX_W'(1))));
  assign w_final    = w_word_end && m_src_last;
  assign w_cut      = w_natural || w_forced || w_final;

  // Next-state and datapath update
  always_comb begin
    w_state       = r_state;
    w_hash        = r_hash;
    w_idx         = r_idx;
    w_len         = r_len;
    w_offset      = r_offset;
    w_cap_hash    = r_cap_hash;
    w_final_nxt   = r_final;
    w_pending_pop = r_pending_pop;
    w_forced_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (m_enable && dc[DC_BIT] && !m_src_empty) w_state = S_RUN;
      end
      S_RUN: begin
        if (!m_src_empty) begin
          w_hash = w_h_next;
          w_len  = w_len_next;
          if (w_cut) begin
            w_cap_hash    = w_h_next;
            w_forced_nxt  = w_forced && !w_natural;
            w_final_nxt   = w_final;
            w_pending_pop = w_word_end;
            w_state       = S_EMIT0;
            if (!w_word_end) w_idx = r_idx + IDX_W'(1);
          end else if (w_word_end) begin
            w_state = S_POP;
          end else begin
            w_idx = r_idx + IDX_W'(1);
          end
        end
      end
      S_POP: begin
        w_idx   = '0;
        w_state = r_final ? S_END : S_RUN;
      end
      S_EMIT0: begin
        if (!m_dst_full) w_state = S_EMIT1;
      end
      S_EMIT1: begin
        if (!m_dst_full) begin
          w_offset = r_offset + r_len[30:0];
          w_len    = 32'd0;
          w_state  = r_pending_pop ? S_POP : S_RUN;
        end
      end
      S_END:   w_state = S_END;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !m_enable) begin
      r_state       <= S_IDLE;
      r_hash        <= 64'h0;
      r_idx         <= '0;
      r_len         <= 32'd0;
      r_offset      <= 31'd0;
      r_cap_hash    <= 64'h0;
      r_final       <= 1'b0;
      r_pending_pop <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_hash        <= w_hash;
      r_idx         <= w_idx;
      r_len         <= w_len;
      r_offset      <= w_offset;
      r_cap_hash    <= w_cap_hash;
      r_final       <= w_final_nxt;
      r_pending_pop <= w_pending_pop;
    end
  end

`ifdef RBCHUNK_FORCED_FLAG_EN
  logic r_forced;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !m_enable)           r_forced <= 1'b0;
    else if (r_state == S_RUN && w_state == S_EMIT0) r_forced <= w_forced_nxt;
  end
  assign w_flag = r_forced;
`else
  logic w_unused_forced;
  assign w_unused_forced = w_forced_nxt;
  assign w_flag = 1'b0;
`endif

  assign w_emit = (r_state == S_EMIT0) || (r_state == S_EMIT1);
  assign w_dst  = (r_state == S_EMIT0) ? r_cap_hash :
                  (r_state == S_EMIT1) ? {w_flag, r_offset, r_len} : 64'h0;

  // Shared engine bus: release every output when this engine is not selected.
  assign m_src_getn = dc[DC_BIT] ? !(r_state == S_POP)              : 1'bz;
  assign m_dst_putn = dc[DC_BIT] ? !(w_emit && !m_dst_full)         : 1'bz;
  assign m_dst      = dc[DC_BIT] ? w_dst                            : 64'bz;
  assign m_dst_last = dc[DC_BIT] ? ((r_state == S_EMIT1) && r_final) : 1'bz;
  assign m_endn     = dc[DC_BIT] ? !(r_state == S_END)              : 1'bz;

endmodule

// File: tb/tb_rbchunk.sv
// Self-checking bench for rbchunk: random byte streams against a chunk-list reference model.
module tb_rbchunk;
  localparam int unsigned SRC_W     = 64;
  localparam int unsigned MASK_BITS = 3;
  localparam int unsigned MIN_CHUNK = 4;
  localparam int unsigned MAX_CHUNK = 16;
  localparam logic [63:0] MAGIC     = 64'h78;
  localparam logic [63:0] SEED      = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] MASKV     = (64'h1 << MASK_BITS) - 64'h1;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        m_enable = 1'b0;
  logic [23:0] dc = 24'h000100;
  logic [63:0] m_src = 64'h0;
  logic        m_src_last = 1'b0;
  logic [2:0]  m_src_nbytes = 3'd0;
  logic        m_src_empty = 1'b1;
  logic        m_src_getn;
  logic [63:0] m_dst;
  logic        m_dst_putn;
  logic        m_dst_last;
  logic        m_dst_full = 1'b0;
  logic        m_endn;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { logic [63:0] w0; logic [63:0] w1; logic last; } rec_t;
  logic [7:0] sbytes[$];
  rec_t       exp_q[$];

  always #5 clk = ~clk;

  rbchunk #(
    .SRC_W(SRC_W), .MASK_BITS(MASK_BITS), .MAGIC(MAGIC), .MIN_CHUNK(MIN_CHUNK),
    .MAX_CHUNK(MAX_CHUNK), .GEAR_SEED(SEED), .DC_BIT(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .m_enable(m_enable), .dc(dc),
    .m_src(m_src), .m_src_last(m_src_last), .m_src_nbytes(m_src_nbytes),
    .m_src_empty(m_src_empty), .m_src_getn(m_src_getn), .m_dst(m_dst),
    .m_dst_putn(m_dst_putn), .m_dst_last(m_dst_last), .m_dst_full(m_dst_full),
    .m_endn(m_endn)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " getn"}, 64'(m_src_getn), 64'd1);
    chk({tag, " putn"}, 64'(m_dst_putn), 64'd1);
    chk({tag, " dst"},  m_dst,           64'd0);
    chk({tag, " last"}, 64'(m_dst_last), 64'd0);
    chk({tag, " endn"}, 64'(m_endn),     64'd1);
  endtask

  // Chunk list straight from the rules: hash every byte, cut on match/max/end.
  task automatic model();
    logic [63:0] h;
    int unsigned len, off;
    logic nat, frc, fin, flag;
    rec_t r;
    h = 64'h0; len = 0; off = 0;
    exp_q.delete();
    for (int i = 0; i < sbytes.size(); i++) begin
      h   = (h << 1) + ((64'(sbytes[i]) * 64'h0101010101010101) ^ SEED);
      len = len + 1;
      nat = (len >= MIN_CHUNK) && ((h & MASKV) == (MAGIC & MASKV));
      frc = (len == MAX_CHUNK);
      fin = (i == sbytes.size() - 1);
      if (nat || frc || fin) begin
`ifdef RBCHUNK_FORCED_FLAG_EN
        flag = frc && !nat;
`else
        flag = 1'b0;
`endif
        r.w0 = h;
        r.w1 = {flag, off[30:0], len};
        r.last = fin;
        exp_q.push_back(r);
        off = off + len;
        len = 0;
      end
    end
  endtask

  task automatic soft_reset();
    @(negedge clk);
    m_enable = 1'b0; m_src_empty = 1'b1;
    @(negedge clk);
    m_enable = 1'b1;
  endtask

  // Feed n random bytes; full_hold cycles of forced backpressure; abort_cyc>0 pulses reset mid-stream.
  task automatic run_stream(input int n, input int full_hold, input int abort_cyc);
    logic [63:0] wq[$];
    logic [63:0] gw[$];
    logic        gl[$];
    logic [63:0] w;
    int nw, last_nb, cur, stall, pops, cyc, max_cyc;
    bit done;
    sbytes.delete();
    for (int i = 0; i < n; i++) sbytes.push_back(8'($urandom));
    nw = (n + 7) / 8;
    last_nb = n % 8;
    for (int k = 0; k < nw; k++) begin
      w = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) if (k*8 + b < n) w[8*b +: 8] = sbytes[k*8 + b];
      wq.push_back(w);
    end
    model();
    cur = 0; stall = int'($urandom_range(0, 2)); pops = 0; cyc = 0; done = 0;
    max_cyc = 100 + 8 * n + full_hold;
    while (!done && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        wb_rst_i = 1'b1; m_src_empty = 1'b1; m_dst_full = 1'b0;
        @(negedge clk);
        wb_rst_i = 1'b0;
        chk_idle("abort reset");
        return;
      end
      if (cur < nw && stall == 0) begin
        m_src_empty  = 1'b0;
        m_src        = wq[cur];
        m_src_last   = (cur == nw - 1);
        m_src_nbytes = (cur == nw - 1) ? 3'(last_nb) : 3'd0;
      end else begin
        if (stall > 0) stall--;
        m_src_empty = 1'b1;
      end
      m_dst_full = (cyc <= full_hold) ? 1'b1 : ($urandom_range(0, 3) == 0);
      #1;
      if (full_hold > 0 && cyc > full_hold - 20 && cyc <= full_hold) begin
        chk("hold getn", 64'(m_src_getn), 64'd1);
        chk("hold putn", 64'(m_dst_putn), 64'd1);
      end
      if (!m_dst_putn) begin gw.push_back(m_dst); gl.push_back(m_dst_last); end
      if (!m_src_getn) begin pops++; cur++; stall = int'($urandom_range(0, 2)); end
      if (!m_endn) done = 1;
    end
    m_dst_full = 1'b0;
    chk("endn reached", 64'(done), 64'd1);
    chk("record words", 64'(gw.size()), 64'(2 * exp_q.size()));
    chk("src pops", 64'(pops), 64'(nw));
    for (int r = 0; r < exp_q.size() && 2*r+1 < gw.size(); r++) begin
      chk($sformatf("rec%0d word0", r), gw[2*r],   exp_q[r].w0);
      chk($sformatf("rec%0d word1", r), gw[2*r+1], exp_q[r].w1);
      chk($sformatf("rec%0d last0", r), 64'(gl[2*r]),   64'd0);
      chk($sformatf("rec%0d last1", r), 64'(gl[2*r+1]), 64'(exp_q[r].last));
    end
    soft_reset();
    chk_idle("after stream");
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    wb_rst_i = 1'b0;
    m_enable = 1'b1;
    chk_idle("reset");

    // Deselected engine releases the bus
    dc = 24'h000000;
    #1;
    n_tests++;
    assert ((m_src_getn === 1'bz || m_src_getn === 1'b0) &&
            (m_dst_putn === 1'bz || m_dst_putn === 1'b0) &&
            (m_endn === 1'bz || m_endn === 1'b0)) else begin
      n_fail++;
      $error("FAIL bus release: observed getn=%b putn=%b endn=%b expected z", m_src_getn, m_dst_putn, m_endn);
    end
    @(negedge clk);
    dc = 24'h000100;
    #1;
    chk_idle("reselect");

    run_stream(40, 0, 0);
    run_stream(16, 0, 0);
    run_stream(40, 60, 0);
    run_stream(11, 0, 0);
    run_stream(1, 0, 0);
    run_stream(40, 0, 6);
    run_stream(8, 0, 0);
    for (int t = 0; t < 12; t++) run_stream(int'($urandom_range(1, 70)), 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
